// File: rtl/pipe_ctrl.sv
// -----------------------------------------------------------------------------
// pipe_ctrl -- stall/flush controller for a six-stage in-order pipeline.
//
// Purpose
//   Merges the per-stage stall requests into a per-stage hold vector.
//   Sequences EX redirects so that a redirect raised while EX is held waits
//   until EX can move. Runs a watchdog that flags a pipeline stalled for too
//   long.
//
// Parameters
//   TIMEOUT  consecutive stalled cycles before timeout_err sets (0 = off).
//            Must be at most 2**CNT_W-1.
//   CNT_W    watchdog counter width.
//
// Ports
//   clk            single clock, all state updates on posedge
//   rst_n          asynchronous active-low reset
//   stallreq_id    ID load-use hazard (holds PC/IF/ID)
//   stallreq_ex    EX multi-cycle unit busy (holds PC..EX)
//   stallreq_mem   data-memory wait (holds PC..MEM)
//   flush_req      EX redirect request, one-cycle pulse
//   flush_pc[63:0] redirect target, valid with flush_req
//   stall[5:0]     per-stage hold: 0 PC, 1 IF, 2 ID, 3 EX, 4 MEM, 5 WB
//   flush          squash IF/ID/EX and load PC from new_pc
//   new_pc[63:0]   registered redirect target
//   timeout_err    sticky watchdog error
//   state_dbg[1:0] current controller state (RUN=0, PEND=1, FLUSH=2)
//
// Handshake
//   flush_req is sampled only in RUN; there is no back-pressure on it.
//   A request seen in PEND or FLUSH is dropped, because the redirect
//   already in flight is older and therefore wins.
//
// Optional feature (macro PIPE_CTRL_PERF_EN)
//   perf_stall_cnt[63:0]  +1 on every cycle with stall[0]=1, wraps
//   perf_flush_cnt[31:0]  +1 on every entry into FLUSH, wraps
// -----------------------------------------------------------------------------
module pipe_ctrl #(
  parameter int unsigned TIMEOUT = 1024,
  parameter int unsigned CNT_W   = 16
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        stallreq_id,
  input  logic        stallreq_ex,
  input  logic        stallreq_mem,
  input  logic        flush_req,
  input  logic [63:0] flush_pc,
  output logic [5:0]  stall,
  output logic        flush,
  output logic [63:0] new_pc,
  output logic        timeout_err,
`ifdef PIPE_CTRL_PERF_EN
  output logic [63:0] perf_stall_cnt,
  output logic [31:0] perf_flush_cnt,
`endif
  output logic [1:0]  state_dbg
);

  typedef enum logic [1:0] {
    RUN   = 2'd0,
    PEND  = 2'd1,
    FLUSH = 2'd2
  } state_t;

  localparam logic [5:0] STALL_MEM = 6'b011111;
  localparam logic [5:0] STALL_EX  = 6'b001111;
  localparam logic [5:0] STALL_ID  = 6'b000111;
  localparam logic [5:0] STALL_NONE = 6'b000000;

  // The watchdog compare is done one bit wider than the counter so that the
  // incremented value never wraps before it is compared with the limit.
  localparam logic [CNT_W:0]   WD_LIMIT = (CNT_W+1)'(TIMEOUT);
  localparam logic [CNT_W-1:0] WD_ONE   = CNT_W'(1);
  localparam logic [CNT_W-1:0] WD_MAX   = {CNT_W{1'b1}};
  localparam bit               WD_EN    = (TIMEOUT != 0);

  state_t state;
  state_t state_nxt;

  logic           accept_req;
  logic           enter_flush;
  logic           stall_any;
  logic [CNT_W-1:0] wd_cnt;
  logic [CNT_W:0]   wd_cnt_inc;
  logic           wd_hit;

  assign state_dbg = state;

  // ---------------------------------------------------------------------------
  // State register
  // ---------------------------------------------------------------------------
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= RUN;
    end else begin
      state <= state_nxt;
    end
  end

  // ---------------------------------------------------------------------------
  // Next state and outputs. In FLUSH the ID/EX requests are ignored: those
  // stages are being squashed anyway, so only a memory wait may hold the
  // pipeline and keep the flush asserted.
  // ---------------------------------------------------------------------------
  always_comb begin
    state_nxt   = state;
    stall       = STALL_NONE;
    flush       = 1'b0;
    accept_req  = 1'b0;
    enter_flush = 1'b0;

    if (state == FLUSH) begin
      if (stallreq_mem) begin
        stall = STALL_MEM;
      end
    end else if (stallreq_mem) begin
      stall = STALL_MEM;
    end else if (stallreq_ex) begin
      stall = STALL_EX;
    end else if (stallreq_id) begin
      stall = STALL_ID;
    end

    unique case (state)
      RUN: begin
        if (flush_req) begin
          accept_req = 1'b1;
          // EX held: the redirecting instruction has not left EX yet, so the
          // squash must wait until EX is released.
          if (stall[3]) begin
            state_nxt = PEND;
          end else begin
            state_nxt   = FLUSH;
            enter_flush = 1'b1;
          end
        end
      end
      PEND: begin
        if (!stallreq_mem && !stallreq_ex) begin
          state_nxt   = FLUSH;
          enter_flush = 1'b1;
        end
      end
      FLUSH: begin
        flush = 1'b1;
        if (!stallreq_mem) begin
          state_nxt = RUN;
        end
      end
      default: begin
        state_nxt = RUN;
      end
    endcase
  end

  // ---------------------------------------------------------------------------
  // Redirect target: captured only when the request is accepted in RUN.
  // ---------------------------------------------------------------------------
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      new_pc <= 64'd0;
    end else if (accept_req) begin
      new_pc <= flush_pc;
    end
  end

  // ---------------------------------------------------------------------------
  // Watchdog. wd_cnt holds the number of consecutive stalled cycles already
  // completed. The error sets on the edge that ends the TIMEOUT-th stalled
  // cycle, which is when the count including the current cycle reaches the
  // limit. The error does not feed back into the stall logic or the FSM.
  // ---------------------------------------------------------------------------
  assign stall_any  = (stall != STALL_NONE);
  assign wd_cnt_inc = {1'b0, wd_cnt} + {{CNT_W{1'b0}}, 1'b1};
  assign wd_hit     = WD_EN && stall_any && (wd_cnt_inc >= WD_LIMIT);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wd_cnt <= '0;
    end else if (!stall_any) begin
      wd_cnt <= '0;
    end else if (wd_cnt != WD_MAX) begin
      wd_cnt <= wd_cnt + WD_ONE;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      timeout_err <= 1'b0;
    end else if (wd_hit) begin
      timeout_err <= 1'b1;
    end
  end

`ifdef PIPE_CTRL_PERF_EN
  // ---------------------------------------------------------------------------
  // Performance counters, free-running and wrapping.
  // ---------------------------------------------------------------------------
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      perf_stall_cnt <= 64'd0;
      perf_flush_cnt <= 32'd0;
    end else begin
      perf_stall_cnt <= perf_stall_cnt + {63'd0, stall[0]};
      perf_flush_cnt <= perf_flush_cnt + {31'd0, enter_flush};
    end
  end
`endif

endmodule

// File: tb/tb_pipe_ctrl.sv
// -----------------------------------------------------------------------------
// tb_pipe_ctrl -- self-checking bench for pipe_ctrl.
//
// The reference model keeps the redirect as two flags: one for "accepted
// but waiting for EX", one for "squash in progress". It counts the stalled
// run length as a plain integer. Redirect targets go into exp_q when they
// are accepted, and one is popped on the first cycle of each flush.
// -----------------------------------------------------------------------------
`timescale 1ns/1ps
module tb_pipe_ctrl;

  localparam int unsigned TIMEOUT = 8;
  localparam int unsigned CNT_W   = 4;

  // clock / reset
  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  logic        stallreq_id = 1'b0;
  logic        stallreq_ex = 1'b0;
  logic        stallreq_mem = 1'b0;
  logic        flush_req = 1'b0;
  logic [63:0] flush_pc = 64'd0;
  logic [5:0]  stall;
  logic        flush;
  logic [63:0] new_pc;
  logic        timeout_err;
  logic [1:0]  state_dbg;
`ifdef PIPE_CTRL_PERF_EN
  logic [63:0] perf_stall_cnt;
  logic [31:0] perf_flush_cnt;
`endif

  pipe_ctrl #(.TIMEOUT(TIMEOUT), .CNT_W(CNT_W)) dut (
    .clk(clk),
    .rst_n(rst_n),
    .stallreq_id(stallreq_id),
    .stallreq_ex(stallreq_ex),
    .stallreq_mem(stallreq_mem),
    .flush_req(flush_req),
    .flush_pc(flush_pc),
    .stall(stall),
    .flush(flush),
    .new_pc(new_pc),
    .timeout_err(timeout_err),
`ifdef PIPE_CTRL_PERF_EN
    .perf_stall_cnt(perf_stall_cnt),
    .perf_flush_cnt(perf_flush_cnt),
`endif
    .state_dbg(state_dbg)
  );

  // scoreboard
  int n_tests = 0;
  int n_fail  = 0;
  logic [63:0] exp_q[$];

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h at %0t", tag, got, exp, $time);
    end
  endtask

  // reference model
  bit          m_waiting;
  bit          m_flushing;
  bit          m_enter;
  logic [63:0] m_pc;
  int          m_run;
  bit          m_err;
  logic [63:0] m_perf_stall;
  logic [31:0] m_perf_flush;

  task automatic model_reset();
    m_waiting = 0;
    m_flushing = 0;
    m_enter = 0;
    m_pc = 64'd0;
    m_run = 0;
    m_err = 0;
    m_perf_stall = 64'd0;
    m_perf_flush = 32'd0;
    exp_q.delete();
  endtask

  function automatic logic [5:0] ref_stall(input bit id, input bit ex, input bit mem);
    if (m_flushing) return mem ? 6'b011111 : 6'b000000;
    if (mem) return 6'b011111;
    if (ex)  return 6'b001111;
    if (id)  return 6'b000111;
    return 6'b000000;
  endfunction

  task automatic check_outputs(input logic [5:0] es);
    check("stall", {58'd0, stall}, {58'd0, es});
    check("flush", {63'd0, flush}, {63'd0, m_flushing});
    check("new_pc", new_pc, m_pc);
    check("timeout_err", {63'd0, timeout_err}, {63'd0, m_err});
`ifdef PIPE_CTRL_PERF_EN
    check("perf_stall_cnt", perf_stall_cnt, m_perf_stall);
    check("perf_flush_cnt", {32'd0, perf_flush_cnt}, {32'd0, m_perf_flush});
`endif
    if (m_enter) begin
      if (exp_q.size() == 0) check("redirect_q_empty", 64'd1, 64'd0);
      else check("redirect_target", new_pc, exp_q.pop_front());
    end
  endtask

  // driver: one clock cycle of stimulus, checked mid-cycle, model stepped on posedge
  task automatic cycle(input bit id, input bit ex, input bit mem, input bit freq,
                       input logic [63:0] fpc);
    logic [5:0] es;
    @(negedge clk);
    stallreq_id = id;
    stallreq_ex = ex;
    stallreq_mem = mem;
    flush_req = freq;
    flush_pc = fpc;
    #1;
    es = ref_stall(id, ex, mem);
    check_outputs(es);
    @(posedge clk);
    if (rst_n) begin
      m_enter = 0;
      if (m_flushing) begin
        m_flushing = mem;
      end else if (m_waiting) begin
        if (!mem && !ex) begin
          m_waiting = 0;
          m_flushing = 1;
          m_enter = 1;
          m_perf_flush++;
        end
      end else if (freq) begin
        m_pc = fpc;
        exp_q.push_back(fpc);
        if (es[3]) m_waiting = 1;
        else begin
          m_flushing = 1;
          m_enter = 1;
          m_perf_flush++;
        end
      end
      m_run = (es != 6'd0) ? m_run + 1 : 0;
      if (TIMEOUT > 0 && m_run >= TIMEOUT) m_err = 1;
      m_perf_stall = m_perf_stall + {63'd0, es[0]};
    end
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) cycle(0, 0, 0, 0, 64'd0);
  endtask

  task automatic apply_reset();
    @(negedge clk);
    rst_n = 1'b0;
    #1;
    model_reset();
    check("rst_flush", {63'd0, flush}, 64'd0);
    check("rst_new_pc", new_pc, 64'd0);
    check("rst_timeout_err", {63'd0, timeout_err}, 64'd0);
    cycle(1, 0, 0, 1, 64'hdead);
    cycle(0, 1, 0, 1, 64'hbeef);
    @(posedge clk);
    #2 rst_n = 1'b1;
  endtask

  initial begin
    #2_000_000;
    $display("FAIL global_timeout: simulation did not finish (got running, expected done)");
    $fatal(1, "timeout");
  end

  initial begin
    model_reset();
    #1;
    check("por_stall", {58'd0, stall}, 64'd0);
    check("por_flush", {63'd0, flush}, 64'd0);
    check("por_new_pc", new_pc, 64'd0);
    check("por_timeout_err", {63'd0, timeout_err}, 64'd0);
    apply_reset();

    // ID stall only for 3 cycles
    for (int i = 0; i < 3; i++) cycle(1, 0, 0, 0, 64'd0);
    idle(2);
    // ID and MEM together
    cycle(1, 0, 1, 0, 64'd0);
    idle(2);
    // unstalled redirect
    cycle(0, 0, 0, 1, 64'h8000_0100);
    idle(3);
    check("req033_new_pc", new_pc, 64'h8000_0100);
    // redirect under an EX stall
    cycle(0, 1, 0, 1, 64'h40);
    for (int i = 0; i < 3; i++) cycle(0, 1, 0, 0, 64'd0);
    idle(3);
    check("req034_new_pc", new_pc, 64'h40);
    // flush held by a memory wait, ID/EX ignored while flushing
    cycle(0, 0, 0, 1, 64'h1234);
    cycle(1, 1, 1, 0, 64'd0);
    cycle(1, 1, 0, 0, 64'd0);
    idle(2);

    // watchdog: 7 stalled + gap, then 8 stalled
    apply_reset();
    for (int i = 0; i < 7; i++) cycle(0, 0, 1, 0, 64'd0);
    idle(1);
    check("req035_no_err", {63'd0, timeout_err}, 64'd0);
    for (int i = 0; i < 8; i++) cycle(0, 0, 1, 0, 64'd0);
    #1;
    check("req035_err_set", {63'd0, timeout_err}, 64'd1);
    for (int i = 0; i < 12; i++) cycle(0, 0, 1, 0, 64'd0);
    idle(3);

    // asynchronous reset while flushing
    apply_reset();
    cycle(0, 0, 0, 1, 64'h77);
    @(negedge clk);
    #1;
    check("pre_rst_flush", {63'd0, flush}, 64'd1);
    rst_n = 1'b0;
    #1;
    check("async_rst_flush", {63'd0, flush}, 64'd0);
    check("async_rst_new_pc", new_pc, 64'd0);
    model_reset();
    cycle(0, 0, 0, 0, 64'd0);
    @(posedge clk);
    #2 rst_n = 1'b1;
    // first request after reset is accepted on the first edge
    cycle(0, 0, 0, 1, 64'h100);
    cycle(0, 0, 0, 0, 64'd0);
    idle(1);
    cycle(0, 0, 0, 1, 64'h200);
    idle(1);
    cycle(0, 0, 0, 1, 64'h300);
    idle(2);
`ifdef PIPE_CTRL_PERF_EN
    check("req036_perf_flush", {32'd0, perf_flush_cnt}, 64'd3);
`endif

    // randomized traffic with occasional resets
    for (int i = 0; i < 3000; i++) begin
      if ($urandom_range(0, 399) == 0) apply_reset();
      cycle($urandom_range(0, 99) < 20, $urandom_range(0, 99) < 18,
            $urandom_range(0, 99) < 14, $urandom_range(0, 99) < 15,
            {$urandom, $urandom});
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
